featuremap_channel_accum: RTL and testbench
===========================================

FEATUREMAP_CHANNEL_ACCUM -- requirements
Module: featuremap_channel_accum

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning signed two's-complement fixed-point sample width.
REQ-002 SHALL have parameter FRAC_BITS, default 8, meaning fractional bits of all samples and bias; it is informational only, since no rescaling is performed.
REQ-003 SHALL have parameter NUM_CH, default 8, range 2..64, meaning number of input channels summed.
REQ-004 SHALL have parameter BIAS, default 0, meaning DATA_WIDTH-bit signed bias in the same format.
REQ-005 SHALL have parameter RELU_EN, default 1, meaning apply ReLU after the bias when 1.
REQ-006 SHALL have parameter WIDTH, default 56, and HEIGHT, default 56, meaning output feature-map dimensions used for frame counting.
REQ-007 SHALL have port clk, input, 1 bit: single clock, all logic rising-edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port data_in, input, NUM_CH*DATA_WIDTH bits: channel c on bits [c*DATA_WIDTH +: DATA_WIDTH], from show-ahead FIFOs.
REQ-010 SHALL have port data_fifo_empty, input, NUM_CH bits: bit c high means channel c FIFO is empty.
REQ-011 SHALL have port rdreq, output, 1 bit: shared read request to all channel FIFOs.
REQ-012 SHALL have port ready_in, input, 1 bit: downstream accepts data_out this cycle.
REQ-013 SHALL have port valid_out, output, 1 bit: data_out holds a valid result.
REQ-014 SHALL have port data_out, output, DATA_WIDTH bits: summed, biased, saturated and optionally rectified result.
REQ-015 SHALL have port last_out, output, 1 bit: high with the final pixel of a WIDTH*HEIGHT frame.

Function
REQ-016 SHALL define adv = ~valid_out | ready_in, the global pipeline enable.
REQ-017 SHALL drive rdreq = adv & (data_fifo_empty == 0), combinationally; no channel is ever read alone.
REQ-018 SHALL, stage 1, on each cycle with rdreq=1, register the exact sign-extended sum of all NUM_CH channels at width DATA_WIDTH+clog2(NUM_CH), and set s1_valid=1.
REQ-019 SHALL, when adv=1 and rdreq=0, clear s1_valid to 0.
REQ-020 SHALL hold all stage-1 and stage-2 registers while adv=0.
REQ-021 SHALL, stage 2, when adv=1, load valid_out <= s1_valid and compute the output in this order:
  - add sign-extended BIAS to the stage-1 sum at full width;
  - saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1];
  - if RELU_EN=1, replace negative results with 0.
REQ-022 SHALL give a latency of exactly 2 cycles from a rdreq=1 edge to valid_out=1, given no stall.
REQ-023 SHALL sustain a throughput of one result per cycle while all FIFOs are non-empty and ready_in=1.
REQ-024 SHALL keep data_out and valid_out stable while valid_out=1 and ready_in=0.
REQ-025 SHALL count completed output handshakes (valid_out & ready_in) in a pixel counter of range 0..WIDTH*HEIGHT-1.
REQ-026 SHALL assert last_out exactly when valid_out=1 and the counter equals WIDTH*HEIGHT-1.
REQ-027 SHALL wrap the counter to 0 on the handshake of that final pixel, with no idle cycle inserted between frames.
REQ-028 SHALL, if any FIFO empties mid-stream, stall input without losing or duplicating data; in-flight results still drain if ready_in=1.
REQ-029 SHALL, on a simultaneous drain and refill (valid_out & ready_in & rdreq), advance both stages in the same cycle.

Reset
REQ-030 SHALL, while rst=0, asynchronously force valid_out=0, s1_valid=0, data_out=0, last_out=0, and pixel counter=0.
REQ-031 SHALL keep rdreq=0 while rst=0.
REQ-032 SHALL, on reset mid-frame, discard in-flight data and restart the next frame at pixel 0.

Verification
REQ-033 SHALL cover the basic case: NUM_CH=8, all channels 0x0100 (1.0), BIAS=0xFF00 (-1.0), ready_in=1 -> data_out=0x0700, 2 cycles after rdreq.
REQ-034 SHALL cover saturation and ReLU: all channels 0x7FFF, BIAS=0 -> data_out=0x7FFF. All channels 0x8000, RELU_EN=1 -> 0x0000; with RELU_EN=0 -> 0x8000.
REQ-035 SHALL cover backpressure: ready_in=0 for 5 cycles while the FIFOs hold data -> at most 2 samples in flight, rdreq=0 after the pipeline fills, data_out stable, no loss on release.
REQ-036 SHALL cover partial empty: one channel's empty=1 for 3 cycles -> rdreq=0 for those cycles, output sequence identical to the unstalled case.
REQ-037 SHALL cover framing: WIDTH=HEIGHT=4, 20 results streamed -> last_out high on the 16th handshake only, counter wraps, 17th result has last_out=0.
REQ-038 SHALL cover reset mid-operation: rst=0 asserted at result 7 -> valid_out=0 immediately; after release, the next frame's last_out lands on its 16th handshake.

Source files
------------

// File: rtl/featuremap_channel_accum.sv
// featuremap_channel_accum
//
// Sums NUM_CH signed fixed-point channels that arrive from show-ahead FIFOs.
// The sum goes through a two-stage pipeline. Stage 1 registers the exact
// channel sum. Stage 2 then adds BIAS, saturates the result to DATA_WIDTH and
// optionally applies ReLU. A pixel counter flags the last pixel of each
// WIDTH*HEIGHT frame on last_out.
//
// Ports
//   clk             : single clock, rising edge
//   rst             : asynchronous, active-low reset
//   data_in         : NUM_CH samples, channel c on [c*DATA_WIDTH +: DATA_WIDTH]
//   data_fifo_empty : per-channel FIFO empty flags
//   rdreq           : shared pop strobe to every channel FIFO
//   ready_in        : downstream accepts data_out this cycle
//   valid_out       : data_out holds a result
//   data_out        : biased, saturated, optionally rectified sum
//   last_out        : valid_out on the final pixel of a frame
//
// Handshake: a result transfers on every rising edge where valid_out and
// ready_in are both high. While valid_out=1 and ready_in=0, data_out,
// valid_out and last_out hold. The whole pipeline advances on
// adv = ~valid_out | ready_in. On the input side, a sample set is consumed on
// every edge where rdreq=1. rdreq only rises when every channel FIFO has data,
// so channels never drift apart.
module featuremap_channel_accum #(
  parameter int                            DATA_WIDTH = 16,
  parameter int                            FRAC_BITS  = 8,
  parameter int                            NUM_CH     = 8,
  parameter logic signed [DATA_WIDTH-1:0]  BIAS       = '0,
  parameter int                            RELU_EN    = 1,
  parameter int                            WIDTH      = 56,
  parameter int                            HEIGHT     = 56
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_CH-1:0]            data_fifo_empty,
  output logic                         rdreq,
  input  logic                         ready_in,
  output logic                         valid_out,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         last_out
);

  // The sum of NUM_CH values needs clog2(NUM_CH) guard bits. Adding the bias
  // can carry one bit further, so stage 2 works one bit wider than that.
  localparam int SUM_W = DATA_WIDTH + $clog2(NUM_CH);
  localparam int EXT_W = SUM_W + 1;
  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);

  localparam logic signed [EXT_W-1:0] SAT_MAX =
    {{(EXT_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    {{(EXT_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Elaboration-time parameter sanity checks.
  if (NUM_CH < 2 || NUM_CH > 64) begin : g_bad_num_ch
    $error("featuremap_channel_accum: NUM_CH must be in 2..64");
  end
  if (FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac_bits
    $error("featuremap_channel_accum: FRAC_BITS must be in 0..DATA_WIDTH-1");
  end

  logic                    adv;
  logic                    s1_valid;
  logic signed [SUM_W-1:0] s1_sum;
  logic signed [SUM_W-1:0] sum_comb;
  logic signed [EXT_W-1:0] biased;
  logic [DATA_WIDTH-1:0]   clipped;
  logic [DATA_WIDTH-1:0]   result;
  logic [CNT_W-1:0]        pix_cnt;

  assign adv = ~valid_out | ready_in;

  // Gating with rst keeps the FIFOs untouched while reset is held. During
  // reset, valid_out=0 would otherwise make adv=1.
  assign rdreq = rst & adv & (data_fifo_empty == '0);

  // Stage-1 adder: sign-extend every channel, then sum at full width.
  always_comb begin
    sum_comb = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sum_comb = sum_comb +
        {{(SUM_W-DATA_WIDTH){data_in[c*DATA_WIDTH+DATA_WIDTH-1]}},
         data_in[c*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

  // Stage-2 datapath: bias, then saturate, then ReLU.
  always_comb begin
    biased = {s1_sum[SUM_W-1], s1_sum} +
             {{(EXT_W-DATA_WIDTH){BIAS[DATA_WIDTH-1]}}, BIAS};
    if (biased > SAT_MAX) begin
      clipped = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (biased < SAT_MIN) begin
      clipped = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      clipped = biased[DATA_WIDTH-1:0];
    end
    if (RELU_EN != 0 && clipped[DATA_WIDTH-1]) begin
      result = '0;
    end else begin
      result = clipped;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      pix_cnt   <= '0;
    end else begin
      // Both stages move together. A drain and a refill in the same cycle
      // therefore need no special case.
      if (adv) begin
        s1_valid <= rdreq;
        if (rdreq) begin
          s1_sum <= sum_comb;
        end
        valid_out <= s1_valid;
        data_out  <= result;
      end
      if (valid_out && ready_in) begin
        pix_cnt <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + 1'b1;
      end
    end
  end

  assign last_out = valid_out & (pix_cnt == LAST_PIX);

endmodule

// File: tb/tb_featuremap_channel_accum.sv
// Bench for featuremap_channel_accum. Two instances share all inputs:
// u_dut (BIAS=-1.0, ReLU on) and u_nrelu (BIAS=0, ReLU off). Both use a 4x4
// frame. The FIFO heads are modelled by an item index; item k carries
// directed vector k%10. Each vector has a hand-computed result per instance.
module tb_featuremap_channel_accum;

  localparam int DW  = 16;
  localparam int NCH = 8;

  logic              clk;
  logic              rst;
  logic [NCH*DW-1:0] data_in;
  logic [NCH-1:0]    data_fifo_empty;
  logic              ready_in;
  logic              rdreq;
  logic              valid_out;
  logic [DW-1:0]     data_out;
  logic              last_out;
  logic              rdreq_b;
  logic              valid_b;
  logic [DW-1:0]     data_b;
  logic              last_b;

  featuremap_channel_accum #(
    .DATA_WIDTH(DW), .FRAC_BITS(8), .NUM_CH(NCH), .BIAS(16'hFF00),
    .RELU_EN(1), .WIDTH(4), .HEIGHT(4)
  ) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_fifo_empty(data_fifo_empty),
    .rdreq(rdreq), .ready_in(ready_in), .valid_out(valid_out),
    .data_out(data_out), .last_out(last_out)
  );

  featuremap_channel_accum #(
    .DATA_WIDTH(DW), .FRAC_BITS(8), .NUM_CH(NCH), .BIAS(16'h0000),
    .RELU_EN(0), .WIDTH(4), .HEIGHT(4)
  ) u_nrelu (
    .clk(clk), .rst(rst), .data_in(data_in), .data_fifo_empty(data_fifo_empty),
    .rdreq(rdreq_b), .ready_in(ready_in), .valid_out(valid_b),
    .data_out(data_b), .last_out(last_b)
  );

  // Hand-computed results for vectors 0..9.
  // u_dut: sum - 256, saturate, ReLU.  u_nrelu: sum, saturate.
  logic [DW-1:0] exp_a_tab [10] = '{16'h0700, 16'h7FFF, 16'h0000, 16'h0000, 16'h00C0,
                                    16'h0000, 16'h0F07, 16'h7F00, 16'h7EF8, 16'h0000};
  logic [DW-1:0] exp_b_tab [10] = '{16'h0800, 16'h7FFF, 16'h8000, 16'hF800, 16'h01C0,
                                    16'hFFFF, 16'h1007, 16'h7FFF, 16'h7FF8, 16'h8000};

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_b_q[$];

  int            n_checks;
  int            n_errors;
  int            idx;
  int            limit;
  int            hs_pos;
  int            hs_total;
  int            n_rd;
  int            n_last;
  int            first_last_hs;
  int            pushes;
  int            pops;
  logic          ready_nx;
  logic [NCH-1:0] force_mask;
  logic          hold_pending;
  logic [DW-1:0] held_a;
  logic [DW-1:0] held_b;
  logic          smp_rdreq;
  logic          smp_valid;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Directed vectors: per vector, the value of channel c.
  function automatic logic [DW-1:0] chan_val(input int v, input int c);
    case (v)
      0:       return 16'h0100;                               // 8 * 1.0
      1:       return 16'h7FFF;                               // positive overflow
      2:       return 16'h8000;                               // negative overflow
      3:       return 16'hFF00;                               // 8 * -1.0
      4:       return 16'(c * 16);                            // ramp, sum 0x1C0
      5:       return (c == 0) ? 16'h7FFF : (c == 1) ? 16'h8000 : 16'h0000;
      6:       return (c == 0) ? 16'h1000 : 16'h0001;         // sum 0x1007
      7:       return (c < 2) ? 16'h4000 : 16'h0000;          // sum 0x8000
      8:       return 16'h0FFF;                               // sum 0x7FF8
      default: return (c == 0) ? 16'h8000 : (c == 1) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // Driver tasks
  task automatic drive_inputs();
    for (int c = 0; c < NCH; c++) begin
      data_in[c*DW +: DW] = (idx < limit) ? chan_val(idx % 10, c) : 16'h0BAD;
    end
    data_fifo_empty = (idx < limit) ? force_mask : '1;
    ready_in        = ready_nx;
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, score, wait for posedge.
  task automatic step();
    @(negedge clk);
    rst = 1'b1;
    drive_inputs();
    #1;
    if (hold_pending) begin
      check("hold_valid", 32'(valid_out), 32'd1);
      check("hold_data", 32'(data_out), 32'(held_a));
      check("hold_data_b", 32'(data_b), 32'(held_b));
    end
    hold_pending = valid_out & ~ready_in;
    held_a       = data_out;
    held_b       = data_b;
    if (valid_out) begin
      check("last", 32'(last_out), 32'(hs_pos == 15));
      check("last_b", 32'(last_b), 32'(hs_pos == 15));
    end
    if (valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(valid_out), 32'd0);
      end else begin
        check("data", 32'(data_out), 32'(exp_q.pop_front()));
        check("data_b", 32'(data_b), 32'(exp_b_q.pop_front()));
        pops++;
        hs_total++;
        if (last_out) begin
          n_last++;
          if (first_last_hs == 0) first_last_hs = hs_total;
        end
        hs_pos = (hs_pos == 15) ? 0 : hs_pos + 1;
      end
    end
    if (rdreq) begin
      exp_q.push_back(exp_a_tab[idx % 10]);
      exp_b_q.push_back(exp_b_tab[idx % 10]);
      idx++;
      n_rd++;
      pushes++;
    end
    smp_rdreq = rdreq;
    smp_valid = valid_out;
  endtask

  task automatic clear_scoreboard();
    exp_q.delete();
    exp_b_q.delete();
    pushes        = 0;
    pops          = 0;
    hs_pos        = 0;
    hs_total      = 0;
    n_last        = 0;
    first_last_hs = 0;
    hold_pending  = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    idx        = 0;
    limit      = 1;
    n_rd       = 0;
    ready_nx   = 1'b1;
    force_mask = '0;
    held_a     = '0;
    held_b     = '0;
    smp_rdreq  = 1'b0;
    smp_valid  = 1'b0;
    clear_scoreboard();
    rst = 1'b0;
    drive_inputs();

    // Reset state: FIFOs report data, but reset must keep rdreq low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_last", 32'(last_out), 32'd0);
    check("rst_rdreq", 32'(rdreq), 32'd0);
    check("rst_valid_b", 32'(valid_b), 32'd0);

    // Latency: rdreq in cycle 0, valid_out visible after the second edge.
    step();
    check("lat_rdreq", 32'(smp_rdreq), 32'd1);
    step();
    check("lat_valid_c1", 32'(smp_valid), 32'd0);
    step();
    check("lat_valid_c2", 32'(smp_valid), 32'd1);

    // Throughput: 12 items with ready_in=1 are read on 12 consecutive cycles.
    limit = idx + 12;
    n_rd  = 0;
    repeat (12) step();
    check("tput_rd", 32'(n_rd), 32'd12);
    repeat (4) step();
    check("tput_drain", 32'(exp_q.size()), 32'd0);

    // Backpressure: ready_in low for 5 cycles, then release.
    limit    = idx + 10;
    ready_nx = 1'b0;
    repeat (5) step();
    check("bp_inflight", 32'(pushes - pops), 32'd2);
    check("bp_rdreq", 32'(smp_rdreq), 32'd0);
    ready_nx = 1'b1;
    repeat (14) step();
    check("bp_drain", 32'(exp_q.size()), 32'd0);
    check("bp_all_read", 32'(idx), 32'(limit));

    // Partial empty: one channel empty for 3 cycles.
    limit      = idx + 8;
    force_mask = 8'h04;
    repeat (3) begin
      step();
      check("pe_rdreq", 32'(smp_rdreq), 32'd0);
    end
    force_mask = '0;
    repeat (12) step();
    check("pe_drain", 32'(exp_q.size()), 32'd0);
    check("pe_all_read", 32'(idx), 32'(limit));

    // Alternating ready_in.
    limit = idx + 6;
    for (int i = 0; i < 16; i++) begin
      ready_nx = i[0];
      step();
    end
    ready_nx = 1'b1;
    repeat (4) step();
    check("alt_drain", 32'(exp_q.size()), 32'd0);

    // Framing over the 37 results so far: lasts on handshakes 16 and 32.
    check("frame_first_last", 32'(first_last_hs), 32'd16);
    check("frame_n_last", 32'(n_last), 32'd2);

    // Reset in mid-frame, at result 7 of the current frame.
    limit = idx + 20;
    for (int i = 0; i < 60 && hs_pos != 7; i++) step();
    check("reach_pos7", 32'(hs_pos), 32'd7);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid_out), 32'd0);
    check("mid_rst_last", 32'(last_out), 32'd0);
    check("mid_rst_rdreq", 32'(rdreq), 32'd0);
    check("mid_rst_valid_b", 32'(valid_b), 32'd0);
    clear_scoreboard();
    @(posedge clk);

    limit = idx + 20;
    repeat (30) step();
    check("post_rst_hs", 32'(hs_total), 32'd20);
    check("post_rst_first_last", 32'(first_last_hs), 32'd16);
    check("post_rst_n_last", 32'(n_last), 32'd1);
    check("post_rst_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
